// File: rtl/decode_pkg.sv
// Shared decode/scoreboard types: register address width, scoreboard FSM states, counter type.
// No logic; sizing helpers only.
// Consumers derive their own counter width from MAX_INFLIGHT through sb_count_width().
package decode_pkg;

   localparam int REG_ADDR_W          = 5;
   localparam int SB_MAX_INFLIGHT_DEF = 3;

   // Pending-write counter width needed to hold 0..max_inflight.
   function automatic int sb_count_width(input int max_inflight);
      return (max_inflight < 1) ? 1 : $clog2(max_inflight + 1);
   endfunction

   localparam int SB_COUNT_W = sb_count_width(SB_MAX_INFLIGHT_DEF);

   typedef logic [REG_ADDR_W-1:0] reg_addr_t;

   // Pending-write count for the default in-flight depth.
   typedef logic [SB_COUNT_W-1:0] sb_count_t;

   typedef enum logic {
      RUN   = 1'b0,
      DRAIN = 1'b1
   } sb_state_t;

endpackage

// File: rtl/sb_counter.sv
// Purpose: one register's pending-write counter, saturating at MAX_INFLIGHT and at zero.
// Latency: the count updates on the clock edge after inc_i/dec_i.
// Backpressure: none; the caller gates inc_i and dec_i, and simultaneous inc_i and dec_i cancel.
module sb_counter
   import decode_pkg::*;
#(
   parameter int MAX_INFLIGHT = SB_MAX_INFLIGHT_DEF,
   parameter int CNT_W        = sb_count_width(MAX_INFLIGHT)
)(
   input  logic             clock,
   input  logic             reset,
   input  logic             inc_i,
   input  logic             dec_i,
   output logic [CNT_W-1:0] count_o
);

   localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_INFLIGHT);

   logic [CNT_W-1:0] count_q, count_d;

   // Next count: a lone inc or dec moves the count; both together leave it unchanged.
   always_comb begin
      count_d = count_q;
      if (inc_i && !dec_i && (count_q != MAX_CNT)) begin
         count_d = count_q + 1'b1;
      end else if (dec_i && !inc_i && (count_q != '0)) begin
         count_d = count_q - 1'b1;
      end
   end

   // Count register with synchronous reset.
   always_ff @(posedge clock) begin
      if (reset) begin
         count_q <= '0;
      end else begin
         count_q <= count_d;
      end
   end

   assign count_o = count_q;

endmodule

// File: rtl/reg_scoreboard.sv
// Purpose: register scoreboard tracking outstanding writes per architectural register; macro SCOREBOARD_BYPASS_EN.
// Latency: issue_ready is combinational from registered counts; counts, busy and flush_done update one edge later.
// Backpressure: issue_ready drops on RAW hazard, destination saturation, or while draining.
module reg_scoreboard
   import decode_pkg::*;
#(
   parameter int NUM_REGS     = 32,
   parameter int MAX_INFLIGHT = SB_MAX_INFLIGHT_DEF
)(
   input  logic                  clock,
   input  logic                  reset,
   input  logic                  issue_valid,
   input  logic [REG_ADDR_W-1:0] issue_rs1,
   input  logic [REG_ADDR_W-1:0] issue_rs2,
   input  logic [REG_ADDR_W-1:0] issue_rd,
   input  logic                  issue_we,
   output logic                  issue_ready,
   input  logic                  wb_valid,
   input  logic [REG_ADDR_W-1:0] wb_addr,
   input  logic                  flush_req,
   output logic                  flush_done,
   output logic                  busy,
   output logic                  wb_error
);

   localparam int               CNT_W     = sb_count_width(MAX_INFLIGHT);
   localparam int               ADDR_SPAN = 2 ** REG_ADDR_W;
   localparam logic [CNT_W-1:0] MAX_CNT   = CNT_W'(MAX_INFLIGHT);
   localparam logic [CNT_W-1:0] ONE_CNT   = CNT_W'(1);

   // Counts indexed by the full address space; untracked entries (x0 and
   // anything at or above NUM_REGS) are tied to zero so lookups stay simple.
   logic [CNT_W-1:0] cnt_all [ADDR_SPAN];

   logic             issue_fire;
   logic [CNT_W-1:0] cnt_rs1, cnt_rs2, cnt_rd, cnt_wb;
   logic             fwd_rs1, fwd_rs2;
   logic             haz_rs1, haz_rs2, sat_rd;
   logic             busy_c, drained_after;

   sb_state_t state_q, state_d;
   logic      flush_done_q, flush_done_d;
   logic      wb_error_q, wb_error_d;

   assign issue_fire = issue_valid & issue_ready;

   for (genvar r = 0; r < ADDR_SPAN; r++) begin : g_reg
      if ((r >= 1) && (r < NUM_REGS)) begin : g_trk
         logic inc, dec;
         assign inc = issue_fire && issue_we && (issue_rd == REG_ADDR_W'(r));
         assign dec = wb_valid && (wb_addr == REG_ADDR_W'(r)) && (cnt_all[r] != '0);
         sb_counter #(
            .MAX_INFLIGHT (MAX_INFLIGHT),
            .CNT_W        (CNT_W)
         ) u_cnt (
            .clock   (clock),
            .reset   (reset),
            .inc_i   (inc),
            .dec_i   (dec),
            .count_o (cnt_all[r])
         );
      end else begin : g_zero
         assign cnt_all[r] = '0;
      end
   end

   assign cnt_rs1 = cnt_all[issue_rs1];
   assign cnt_rs2 = cnt_all[issue_rs2];
   assign cnt_rd  = cnt_all[issue_rd];
   assign cnt_wb  = cnt_all[wb_addr];

`ifdef SCOREBOARD_BYPASS_EN
   // The last outstanding write to a source retires this cycle and the
   // writeback path forwards its value, so the source is already usable.
   assign fwd_rs1 = wb_valid && (wb_addr == issue_rs1) && (cnt_rs1 == ONE_CNT);
   assign fwd_rs2 = wb_valid && (wb_addr == issue_rs2) && (cnt_rs2 == ONE_CNT);
`else
   // No forwarding: a source waits until its count is registered as zero.
   assign fwd_rs1 = 1'b0;
   assign fwd_rs2 = 1'b0;
`endif

   // x0 always reads a zero count, so it never hazards or saturates.
   assign haz_rs1 = (cnt_rs1 != '0) && !fwd_rs1;
   assign haz_rs2 = (cnt_rs2 != '0) && !fwd_rs2;
   assign sat_rd  = issue_we && (issue_rd != '0) && (cnt_rd == MAX_CNT);

   // Busy from registered counts; drained means every count is zero once this cycle's writeback lands.
   always_comb begin
      busy_c        = 1'b0;
      drained_after = 1'b1;
      for (int r = 0; r < ADDR_SPAN; r++) begin
         if (cnt_all[r] != '0) begin
            busy_c = 1'b1;
            if (!(wb_valid && (wb_addr == REG_ADDR_W'(r)) && (cnt_all[r] == ONE_CNT))) begin
               drained_after = 1'b0;
            end
         end
      end
   end

   assign busy = busy_c;

   // Sticky error: any writeback that finds no outstanding write to retire.
   always_comb begin
      wb_error_d = wb_error_q;
      if (wb_valid && (cnt_wb == '0)) begin
         wb_error_d = 1'b1;
      end
   end

   // FSM next state and issue gating; issue is blocked for the whole drain.
   always_comb begin
      state_d      = state_q;
      flush_done_d = 1'b0;
      issue_ready  = 1'b0;
      case (state_q)
         RUN: begin
            issue_ready = !haz_rs1 && !haz_rs2 && !sat_rd;
            if (flush_req) begin
               state_d = DRAIN;
            end
         end
         DRAIN: begin
            if (drained_after) begin
               state_d      = RUN;
               flush_done_d = 1'b1;
            end
         end
         default: begin
            state_d = RUN;
         end
      endcase
   end

   // State, completion pulse and error flag; reset overrides all same-cycle activity.
   always_ff @(posedge clock) begin
      if (reset) begin
         state_q      <= RUN;
         flush_done_q <= 1'b0;
         wb_error_q   <= 1'b0;
      end else begin
         state_q      <= state_d;
         flush_done_q <= flush_done_d;
         wb_error_q   <= wb_error_d;
      end
   end

   assign flush_done = flush_done_q;
   assign wb_error   = wb_error_q;

endmodule

// File: tb/tb_reg_scoreboard.sv
// Directed table of per-cycle stimulus with expected outputs, plus a reset-during-drain sequence.
// issue_ready is checked mid-cycle; busy, wb_error and flush_done are checked just after the edge.
module tb_reg_scoreboard;

`ifdef SCOREBOARD_BYPASS_EN
   localparam logic BYP = 1'b1;
`else
   localparam logic BYP = 1'b0;
`endif

   logic       clock = 1'b0;
   logic       reset;
   logic       issue_valid;
   logic [4:0] issue_rs1, issue_rs2, issue_rd;
   logic       issue_we;
   logic       issue_ready;
   logic       wb_valid;
   logic [4:0] wb_addr;
   logic       flush_req;
   logic       flush_done;
   logic       busy;
   logic       wb_error;

   int total = 0;
   int bad   = 0;

   reg_scoreboard dut (
      .clock       (clock),
      .reset       (reset),
      .issue_valid (issue_valid),
      .issue_rs1   (issue_rs1),
      .issue_rs2   (issue_rs2),
      .issue_rd    (issue_rd),
      .issue_we    (issue_we),
      .issue_ready (issue_ready),
      .wb_valid    (wb_valid),
      .wb_addr     (wb_addr),
      .flush_req   (flush_req),
      .flush_done  (flush_done),
      .busy        (busy),
      .wb_error    (wb_error)
   );

   always #5 clock = ~clock;

   typedef struct {
      logic       v;
      logic [4:0] rs1, rs2, rd;
      logic       we;
      logic       wbv;
      logic [4:0] wba;
      logic       fl;
      logic       e_rdy, e_busy, e_err, e_fd;
   } vec_t;

   vec_t tbl[$];

   function automatic vec_t mk(input logic v, input int rs1, input int rs2, input int rd,
                               input logic we, input logic wbv, input int wba, input logic fl,
                               input logic e_rdy, input logic e_busy, input logic e_err,
                               input logic e_fd);
      vec_t t;
      t.v = v; t.rs1 = 5'(rs1); t.rs2 = 5'(rs2); t.rd = 5'(rd); t.we = we;
      t.wbv = wbv; t.wba = 5'(wba); t.fl = fl;
      t.e_rdy = e_rdy; t.e_busy = e_busy; t.e_err = e_err; t.e_fd = e_fd;
      return t;
   endfunction

   task automatic chk(input string nm, input int row, input logic got, input logic exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s row=%0d got=%0b exp=%0b", nm, row, got, exp);
      end
   endtask

   task automatic drive(input logic v, input int rs1, input int rs2, input int rd, input logic we,
                        input logic wbv, input int wba, input logic fl);
      issue_valid = v; issue_rs1 = 5'(rs1); issue_rs2 = 5'(rs2); issue_rd = 5'(rd);
      issue_we = we; wb_valid = wbv; wb_addr = 5'(wba); flush_req = fl;
   endtask

   initial begin
      reset = 1'b1;
      drive(0, 0, 0, 0, 0, 0, 0, 0);

      //           v rs1 rs2 rd we wbv wba fl   rdy busy err fd
      tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0,   1, 0, 0, 0));  // 0 idle
      tbl.push_back(mk(1, 0, 0, 5, 1, 0, 0, 0,   1, 1, 0, 0));  // 1 write r5
      tbl.push_back(mk(1, 5, 0, 0, 0, 0, 0, 0,   0, 1, 0, 0));  // 2 RAW on r5
      tbl.push_back(mk(1, 5, 0, 0, 0, 1, 5, 0, BYP, 0, 0, 0));  // 3 RAW + wb r5
      tbl.push_back(mk(1, 5, 0, 0, 0, 0, 0, 0,   1, 0, 0, 0));  // 4 r5 clear
      tbl.push_back(mk(1, 0, 0, 7, 1, 0, 0, 0,   1, 1, 0, 0));  // 5 r7 ->1
      tbl.push_back(mk(1, 0, 0, 7, 1, 0, 0, 0,   1, 1, 0, 0));  // 6 r7 ->2
      tbl.push_back(mk(1, 0, 0, 7, 1, 0, 0, 0,   1, 1, 0, 0));  // 7 r7 ->3
      tbl.push_back(mk(1, 0, 0, 7, 1, 0, 0, 0,   0, 1, 0, 0));  // 8 saturated
      tbl.push_back(mk(1, 0, 0, 7, 1, 1, 7, 0,   0, 1, 0, 0));  // 9 still stalled, r7 ->2
      tbl.push_back(mk(1, 0, 0, 7, 1, 0, 0, 0,   1, 1, 0, 0));  // 10 fourth accepted ->3
      tbl.push_back(mk(0, 0, 0, 0, 0, 1, 7, 0,   1, 1, 0, 0));  // 11 r7 ->2
      tbl.push_back(mk(0, 0, 0, 0, 0, 1, 7, 0,   1, 1, 0, 0));  // 12 r7 ->1
      tbl.push_back(mk(0, 0, 0, 0, 0, 1, 7, 0,   1, 0, 0, 0));  // 13 r7 ->0
      tbl.push_back(mk(1, 0, 0, 9, 1, 0, 0, 0,   1, 1, 0, 0));  // 14 r9 ->1
      tbl.push_back(mk(1, 0, 0, 9, 1, 1, 9, 0,   1, 1, 0, 0));  // 15 inc+dec r9 stays 1
      tbl.push_back(mk(0, 0, 0, 0, 0, 1, 9, 0,   1, 0, 0, 0));  // 16 r9 ->0
      tbl.push_back(mk(1, 0, 0, 3, 1, 0, 0, 0,   1, 1, 0, 0));  // 17 r3 ->1
      tbl.push_back(mk(1, 0, 0, 4, 1, 0, 0, 0,   1, 1, 0, 0));  // 18 r4 ->1
      tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 1,   1, 1, 0, 0));  // 19 flush -> DRAIN
      tbl.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0,   0, 1, 0, 0));  // 20 draining
      tbl.push_back(mk(1, 0, 0, 0, 0, 1, 3, 0,   0, 1, 0, 0));  // 21 wb r3
      tbl.push_back(mk(1, 0, 0, 0, 0, 1, 4, 1,   0, 0, 0, 1));  // 22 wb r4 drains, flush ignored
      tbl.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0,   1, 0, 0, 0));  // 23 back in RUN, pulse gone
      tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 1,   1, 0, 0, 0));  // 24 flush while idle
      tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0,   0, 0, 0, 1));  // 25 drain completes
      tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0,   1, 0, 0, 0));  // 26 RUN
      tbl.push_back(mk(0, 0, 0, 0, 0, 1, 12, 0,  1, 0, 1, 0));  // 27 wb to zero count
      tbl.push_back(mk(1, 0, 0, 0, 1, 0, 0, 0,   1, 0, 1, 0));  // 28 write x0 ignored
      tbl.push_back(mk(1, 0, 0, 12, 1, 0, 0, 0,  1, 1, 1, 0));  // 29 r12 ->1
      tbl.push_back(mk(0, 0, 0, 0, 0, 1, 12, 0,  1, 0, 1, 0));  // 30 r12 ->0
      tbl.push_back(mk(1, 0, 0, 6, 1, 0, 0, 0,   1, 1, 1, 0));  // 31 r6 ->1
      tbl.push_back(mk(1, 0, 6, 0, 0, 0, 0, 0,   0, 1, 1, 0));  // 32 RAW via rs2
      tbl.push_back(mk(1, 0, 6, 0, 0, 1, 6, 0, BYP, 0, 1, 0));  // 33 RAW rs2 + wb r6
      tbl.push_back(mk(1, 0, 6, 0, 0, 0, 0, 0,   1, 0, 1, 0));  // 34 r6 clear

      @(posedge clock); @(posedge clock); #1;
      chk("rst_busy", -1, busy, 1'b0);
      chk("rst_err",  -1, wb_error, 1'b0);
      chk("rst_fd",   -1, flush_done, 1'b0);
      reset = 1'b0;
      #1;
      chk("rst_ready", -1, issue_ready, 1'b1);

      for (int i = 0; i < tbl.size(); i++) begin
         drive(tbl[i].v, int'(tbl[i].rs1), int'(tbl[i].rs2), int'(tbl[i].rd), tbl[i].we,
               tbl[i].wbv, int'(tbl[i].wba), tbl[i].fl);
         #2;
         chk("ready", i, issue_ready, tbl[i].e_rdy);
         @(posedge clock); #1;
         chk("busy", i, busy, tbl[i].e_busy);
         chk("err",  i, wb_error, tbl[i].e_err);
         chk("fd",   i, flush_done, tbl[i].e_fd);
      end

      // Reset in the middle of a drain, colliding with issue, writeback and flush.
      drive(1, 0, 0, 3, 1, 0, 0, 0);
      @(posedge clock); #1;
      drive(1, 0, 0, 4, 1, 0, 0, 0);
      @(posedge clock); #1;
      drive(0, 0, 0, 0, 0, 0, 0, 1);
      @(posedge clock); #1;
      drive(1, 0, 0, 0, 0, 0, 0, 0);
      #2;
      chk("drain_ready", 100, issue_ready, 1'b0);
      chk("drain_busy",  100, busy, 1'b1);
      @(posedge clock); #1;
      reset = 1'b1;
      drive(1, 0, 0, 5, 1, 1, 3, 1);
      @(posedge clock); #1;
      reset = 1'b0;
      drive(0, 0, 0, 0, 0, 0, 0, 0);
      #1;
      chk("rd_busy",  101, busy, 1'b0);
      chk("rd_fd",    101, flush_done, 1'b0);
      chk("rd_err",   101, wb_error, 1'b0);
      chk("rd_ready", 101, issue_ready, 1'b1);
      @(posedge clock); #1;
      chk("rd_fd2",   102, flush_done, 1'b0);
      chk("rd_busy2", 102, busy, 1'b0);
      // r3 was cleared by reset, so retiring it now is an error.
      drive(0, 0, 0, 0, 0, 1, 3, 0);
      @(posedge clock); #1;
      chk("rd_err2",  103, wb_error, 1'b1);
      chk("rd_busy3", 103, busy, 1'b0);
      drive(0, 0, 0, 0, 0, 0, 0, 0);
      @(posedge clock); #1;

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
